chunked_addsub: RTL and testbench
=================================

Name: chunked_addsub

Overview:
- Parametrised, multi-cycle successor to the 64-bit ripple-carry adder.
- Computes a WIDTH-bit add or subtract with carry-in. It processes CHUNK bits per clock through a registered carry chain, so critical-path length is set by CHUNK rather than WIDTH.
- Valid/ready handshakes on both the operand side and the result side.
- Sits between an operand source (register file or testbench driver) and a result consumer. It replaces the flat combinational adder where timing closure at WIDTH=64 fails.

Parameters:
- WIDTH, 64, operand and result width in bits.
- CHUNK, 16, bits added per cycle. WIDTH % CHUNK must be 0 and CHUNK >= 1; an elaboration error is raised otherwise.
- NCHUNK, WIDTH/CHUNK (derived, not overridable), cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- c_out  output  1  carry-out (add); in sub mode 1 = no borrow
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: the only reset is synchronous, active-high `rst`, sampled on the rising edge of the single clock `clk`.
  - state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0.
  - Chunk index=0, carry register=0.
- States and transitions:
  - IDLE -> RUN on in_valid && in_ready. In the same edge, latch a and b_eff, and preset the carry register.
    - Add: b_eff = b, carry preset = c_in. Result sum = a + b + c_in.
    - Sub: b_eff = ~b, carry preset = ~c_in. Result sum = a - b - c_in.
  - RUN: each cycle, chunk i = a[i*CHUNK +: CHUNK] + b_eff[...] + carry is written into the sum register. The carry register is updated and i increments.
  - RUN -> DONE on the edge that writes chunk NCHUNK-1. That edge also captures c_out = final carry and ovf = carry into MSB XOR carry out of MSB.
  - DONE -> IDLE on out_valid && out_ready.
- Outputs per state:
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Latency: operands accepted at edge k; out_valid is high after edge k+NCHUNK (4 cycles at default parameters).
  - Throughput: one operation per NCHUNK+1 cycles minimum.
  - No overlap of operations.
- Operand inputs are ignored outside IDLE, and latched values are immune to input changes.
- sum, c_out and ovf are held stable throughout DONE while out_ready=0 (backpressure). They retain their values in IDLE until the next operation's chunks overwrite them.
- NCHUNK=1: RUN lasts one cycle; behaviour is otherwise identical.
- Reset mid-operation (RUN or DONE): the next state is IDLE with all reset values. The partial result is discarded and no out_valid pulse is produced.
- in_valid asserted in the same cycle as rst: ignored.

Decomposition:
- Shared package `addsub_pkg`:
  - state enum (IDLE, RUN, DONE), 2-bit encoding.
  - localparam function computing NCHUNK.
  - parameter-legality check.
- Sub-module `chunk_adder`: combinational CHUNK-bit ripple-carry adder with inputs a, b, c_in and outputs sum, c_out, c_msb.
  - c_msb is the carry into the top bit; it is used for ovf on the last chunk.
  - It is instantiated once and time-multiplexed across chunks.
- Bench reference: behavioural `a + b_eff + cin` at WIDTH+1 bits.

Test Plan:
- Add all-ones, no carry: a=b=64'hFFFFFFFFFFFFFFFF, c_in=0, sub=0 -> sum=64'hFFFFFFFFFFFFFFFE, c_out=1, ovf=0. out_valid asserts exactly 4 cycles after accept.
- Add all-ones with carry: a=b=64'hFFFFFFFFFFFFFFFF, c_in=1 -> sum=64'hFFFFFFFFFFFFFFFF, c_out=1, ovf=0.
- Mixed operands: a=64'h508BBE0301D2D287, b=64'hDF181EA770DB8BB5, c_in=0 -> sum=64'h2FA3DCAA72AE5E3C, c_out=1, ovf=0.
- Small add: a=64'h6A, b=64'h4, c_in=0 -> sum=64'h6E, c_out=0.
- Signed overflow: a=64'h7FFFFFFFFFFFFFFF, b=1, c_in=0 -> sum=64'h8000000000000000, c_out=0, ovf=1.
- Subtract and control:
  - sub=1, a=64'h10, b=64'h11, c_in=0 -> sum=64'hFFFFFFFFFFFFFFFF, c_out=0 (borrow), ovf=0.
  - Hold out_ready=0 for 5 cycles -> sum stable, in_ready=0.
  - Separately, assert rst 2 cycles after an accept -> next cycle in_ready=1, out_valid=0, and no result is ever produced.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the chunked add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Guarded so an illegal CHUNK of 0 never divides by zero during elaboration.
  function automatic int calc_nchunk(input int width, input int chunk);
    if (chunk < 1) return 1;
    return width / chunk;
  endfunction

  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    if (chunk < 1) return 1'b0;
    if (width < chunk) return 1'b0;
    return (width % chunk) == 0;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice, time-multiplexed across the chunks of an operand.
module chunk_adder #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
  assign sum   = full[CHUNK-1:0];
  assign c_out = full[CHUNK];
  // Carry into the top bit recovered from the top bit's own sum equation.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit add/subtract with carry-in, CHUNK bits per clock, valid/ready on both sides.
//   state | meaning
//   IDLE  | ready for operands; previous result still visible on sum/c_out/ovf
//   RUN   | one chunk per clock through the registered carry chain
//   DONE  | result valid, held until out_ready
module chunked_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("chunked_addsub: CHUNK must be >= 1 and divide WIDTH");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]   ch_sum;
  logic               ch_cout;
  logic               ch_msb;
  logic               last_chunk;

  // Operand registers shift right each RUN cycle so the adder always reads the low chunk.
  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .c_in  (carry_q),
    .sum   (ch_sum),
    .c_out (ch_cout),
    .c_msb (ch_msb)
  );

  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~c_in : c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = ch_sum;
        carry_d = ch_cout;
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        idx_d   = idx_q + IDX_W'(1);
        if (last_chunk) begin
          c_out_d = ch_cout;
          ovf_d   = ch_cout ^ ch_msb;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed bench for chunked_addsub: arithmetic reference model plus literal expectations.
module tb_chunked_addsub;

  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } res_t;

  res_t exp_q[$];

  chunked_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: whole-word arithmetic at WIDTH+1 bits, overflow from operand/result signs.
  function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic ci, input logic sb);
    res_t             r;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] be;
    logic             ce;
    be   = sb ? ~bv : bv;
    ce   = sb ? ~ci : ci;
    t    = {1'b0, av} + {1'b0, be} + {{WIDTH{1'b0}}, ce};
    r.s  = t[WIDTH-1:0];
    r.co = t[WIDTH];
    r.ov = (av[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != av[WIDTH-1]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: out_valid=1 with sum %h but no operation outstanding at %0t",
                 sum, $time);
      end else begin
        chk("model_sum", sum, exp_q[0].s);
        chk("model_c_out", WIDTH'(c_out), WIDTH'(exp_q[0].co));
        chk("model_ovf", WIDTH'(ovf), WIDTH'(exp_q[0].ov));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic ci, input logic sb, input int hold, input bit lit,
                       input logic [WIDTH-1:0] es, input logic eco, input logic eov);
    int               w;
    logic [WIDTH-1:0] held;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_idle", WIDTH'(in_ready), WIDTH'(1));
    if (!in_ready) return;
    a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    exp_q.push_back(model(av, bv, ci, sb));
    // Garbage on the operand inputs while busy must not disturb the latched operation.
    a = ~av; b = {$urandom, $urandom}; c_in = ~ci; sub = ~sb;
    for (int k = 1; k <= NCHUNK; k++) begin
      chk("busy_in_ready", WIDTH'(in_ready), WIDTH'(0));
      chk("early_out_valid", WIDTH'(out_valid), WIDTH'(0));
      @(posedge clk); #1;
      if (k == NCHUNK - 1) in_valid = 1'b0;
    end
    chk("latency_out_valid", WIDTH'(out_valid), WIDTH'(1));
    held = sum;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_sum_stable", sum, held);
      chk("hold_in_ready", WIDTH'(in_ready), WIDTH'(0));
      chk("hold_out_valid", WIDTH'(out_valid), WIDTH'(1));
    end
    out_ready = 1'b1;
    if (lit) begin
      chk("lit_sum", sum, es);
      chk("lit_c_out", WIDTH'(c_out), WIDTH'(eco));
      chk("lit_ovf", WIDTH'(ovf), WIDTH'(eov));
    end
    @(posedge clk); #1;
    chk("after_hs_out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("after_hs_in_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("idle_keeps_sum", sum, held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("reset_out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("reset_sum", sum, '0);
    chk("reset_c_out", WIDTH'(c_out), WIDTH'(0));
    chk("reset_ovf", WIDTH'(ovf), WIDTH'(0));

    do_op(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 0, 1'b1,
          64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b0);
    do_op(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 0, 1'b1,
          64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0);
    do_op(64'h508BBE0301D2D287, 64'hDF181EA770DB8BB5, 1'b0, 1'b0, 0, 1'b1,
          64'h2FA3DCAA72AE5E3C, 1'b1, 1'b0);
    do_op(64'h6A, 64'h4, 1'b0, 1'b0, 0, 1'b1, 64'h6E, 1'b0, 1'b0);
    do_op(64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 0, 1'b1,
          64'h8000000000000000, 1'b0, 1'b1);
    do_op(64'h10, 64'h11, 1'b0, 1'b1, 5, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    // Subtract with borrow-in, negative overflow, and a carry rippling across every chunk boundary.
    do_op(64'h100, 64'h1, 1'b1, 1'b1, 0, 1'b1, 64'hFE, 1'b1, 1'b0);
    do_op(64'h8000000000000000, 64'h1, 1'b0, 1'b1, 2, 1'b1,
          64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1);
    do_op(64'h0000FFFFFFFFFFFF, 64'h0, 1'b1, 1'b0, 0, 1'b1,
          64'h0001000000000000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), i % 3,
            1'b0, '0, 1'b0, 1'b0);

    // Reset two cycles after an accept discards the operation.
    a = 64'h1234; b = 64'h5678; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(64'h1234, 64'h5678, 1'b0, 1'b0));
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("midrst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("midrst_sum", sum, '0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_result", WIDTH'(out_valid), WIDTH'(0));
    end

    // in_valid together with rst is ignored.
    a = 64'h55; b = 64'h66; rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_inv_in_ready", WIDTH'(in_ready), WIDTH'(1));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("rst_inv_no_result", WIDTH'(out_valid), WIDTH'(0));
    end

    do_op(64'h1, 64'h2, 1'b1, 1'b0, 0, 1'b1, 64'h4, 1'b0, 1'b0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL outstanding_results: %0d expected results never appeared", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
